muldiv8_result_serializer: RTL and testbench

Result-side back end of the 8-bit multiply/divide core: buffers each completed result (16-bit product, or 8-bit quotient plus 8-bit remainder) in a small FIFO and presents it to the host one byte at a time on the 8-bit output pins. The host steps bytes with a strobe level driven on a bidirectional input. Sits between the muldiv core's result register and the top-level `uo_out` mux, so the core can start the next operation before the host has read the previous result.

---
 rtl/muldiv8_result_serializer.sv | 128 ++++++++++++
 tb/tb_muldiv8_result_serializer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv8_result_serializer.sv
// Buffers muldiv results in a small FIFO and presents them one byte per host strobe step.
// Optional status byte (flags) is enabled with `define MULDIV8_RESSER_STATUS_EN.
module muldiv8_result_serializer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [15:0]              res_data,
  input  logic [1:0]               res_flags,
  input  logic                     rd_strobe,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  output logic [1:0]               byte_sel,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

`ifdef MULDIV8_RESSER_STATUS_EN
  typedef enum logic [1:0] {IDLE, LO, HI, ST} state_t;
`else
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
`endif

  state_t          state, next;
  logic [17:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [17:0]     head;
  logic            push, pop, more;
  logic            s1, s2, s3, step;

  assign res_ready = (level != (AW+1)'(DEPTH));
  assign push      = res_valid && res_ready;
  assign head      = mem[rd_ptr];
  assign more      = (level > (AW+1)'(1));

  // s1/s2 resynchronise the host level; s3 delays it so only rising edges make a step
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rd_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {res_flags, res_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (res_valid && !res_ready) overflow <= 1'b1;
    end
  end

  always_comb begin
    next       = state;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_sel   = 2'd0;
    byte_out   = 8'h00;
    case (state)
      IDLE: begin
        if (level != '0) next = LO;
      end
      LO: begin
        byte_valid = 1'b1;
        byte_out   = head[7:0];
        if (step) next = HI;
      end
      HI: begin
        byte_valid = 1'b1;
        byte_sel   = 2'd1;
        byte_out   = head[15:8];
        if (step) begin
`ifdef MULDIV8_RESSER_STATUS_EN
          next = ST;
`else
          // the popped entry still counts in level, so a second entry means level > 1
          pop  = 1'b1;
          next = more ? LO : IDLE;
`endif
        end
      end
`ifdef MULDIV8_RESSER_STATUS_EN
      ST: begin
        byte_valid = 1'b1;
        byte_sel   = 2'd2;
        byte_out   = {6'b0, head[17:16]};
        if (step) begin
          pop  = 1'b1;
          next = more ? LO : IDLE;
        end
      end
`endif
      default: next = IDLE;
    endcase
  end

`ifndef MULDIV8_RESSER_STATUS_EN
  logic unused_flags;
  assign unused_flags = ^head[17:16];
`endif

endmodule

// File: tb/tb_muldiv8_result_serializer.sv
// Self-checking bench: queue-based reference model of the serializer, directed scenarios plus random traffic.
module tb_muldiv8_result_serializer;

  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int VW    = 13 + LW;
`ifdef MULDIV8_RESSER_STATUS_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [15:0]   res_data = '0;
  logic [1:0]    res_flags = '0;
  logic          rd_strobe = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic [1:0]    byte_sel;
  logic          overflow;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // reference model: result queue, byte position within the head result (-1 = idle)
  logic [17:0] q[$];
  int          pos = -1;
  bit          ovf = 1'b0;
  bit [2:0]    hist = '0;   // strobe samples at the last three edges, [0] newest

  muldiv8_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .rd_strobe(rd_strobe),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_sel(byte_sel),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] dut_vec = {byte_valid, byte_sel, byte_out, res_ready, overflow, level};

  function automatic logic [VW-1:0] exp_vec();
    logic [7:0] b = 8'h00;
    logic [1:0] s = 2'd0;
    logic       v = 1'b0;
    if (pos >= 0) begin
      v = 1'b1;
      s = pos[1:0];
      case (pos)
        0:       b = q[0][7:0];
        1:       b = q[0][15:8];
        default: b = {6'b0, q[0][17:16]};
      endcase
    end
    return {v, s, b, (q.size() < DEPTH), ovf, LW'(q.size())};
  endfunction

  // advance one edge for both DUT and model, then settle before sampling
  task automatic tick();
    bit stp, rdy, psh, pp;
    int n;
    @(posedge clk);
    if (rst) begin
      q.delete();
      pos  = -1;
      ovf  = 1'b0;
      hist = '0;
    end else begin
      n   = q.size();
      stp = hist[1] & ~hist[2];
      rdy = (n < DEPTH);
      psh = res_valid && rdy;
      pp  = 1'b0;
      if (res_valid && !rdy) ovf = 1'b1;
      if (pos < 0) begin
        if (n > 0) pos = 0;
      end else if (stp) begin
        if (pos == NB - 1) begin
          pp  = 1'b1;
          pos = (n > 1) ? 0 : -1;
        end else begin
          pos = pos + 1;
        end
      end
      if (pp) void'(q.pop_front());
      if (psh) q.push_back({res_flags, res_data});
      hist = {hist[1:0], rd_strobe};
    end
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] f);
    res_valid = 1'b1;
    res_data  = d;
    res_flags = f;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    rd_strobe = 1'b1;
    repeat (hi) tick();
    rd_strobe = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (pos >= 0 || q.size() > 0); i++) begin
      if (pos < 0) tick();
      else pulse(3, 3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if (dut_vec !== {1'b0, 2'd0, 8'h00, 1'b1, 1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, {1'b0, 2'd0, 8'h00, 1'b1, 1'b0, LW'(0)});
    end
  endtask

  task automatic test_multiply();
    push(16'h03A8, 2'b00);
    tick();
    checks++;
    if ({byte_valid, byte_sel, byte_out} !== {1'b1, 2'd0, 8'hA8}) begin
      errors++;
      $display("FAIL mul_lo: got %h expected %h", {byte_valid, byte_sel, byte_out}, {1'b1, 2'd0, 8'hA8});
    end
    pulse(3, 3);
    checks++;
    if ({byte_valid, byte_sel, byte_out} !== {1'b1, 2'd1, 8'h03}) begin
      errors++;
      $display("FAIL mul_hi: got %h expected %h", {byte_valid, byte_sel, byte_out}, {1'b1, 2'd1, 8'h03});
    end
    pulse(3, 3);
`ifdef MULDIV8_RESSER_STATUS_EN
    checks++;
    if ({byte_valid, byte_sel, byte_out} !== {1'b1, 2'd2, 8'h00}) begin
      errors++;
      $display("FAIL mul_status: got %h expected %h", {byte_valid, byte_sel, byte_out}, {1'b1, 2'd2, 8'h00});
    end
    pulse(3, 3);
`endif
    checks++;
    if ({byte_valid, byte_out} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mul_done: got %h expected %h", {byte_valid, byte_out}, {1'b0, 8'h00});
    end
  endtask

  task automatic test_divide();
    logic [7:0] want [6];
    logic [7:0] got;
    int         k = 0;
    want[0] = 8'h1C; want[1] = 8'h04; want[2] = 8'h01;
    want[3] = 8'hFF; want[4] = 8'h00; want[5] = 8'h03;
    push(16'h041C, 2'b01);
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < NB; b++) begin
        got = byte_out;
        checks++;
        if (got !== want[r*3+b] || byte_sel !== 2'(b)) begin
          errors++;
          $display("FAIL div_byte%0d_%0d: got %h sel %0d expected %h sel %0d", r, b, got, byte_sel, want[r*3+b], b);
        end
        pulse(3, 3);
        k++;
      end
      if (r == 0) begin
        push(16'h00FF, 2'b11);
        tick();
      end
    end
    checks++;
    if (byte_valid !== 1'b0 || k != 2*NB) begin
      errors++;
      $display("FAIL div_done: got valid %b bytes %0d expected valid 0 bytes %0d", byte_valid, k, 2*NB);
    end
  endtask

  task automatic test_overflow();
    res_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_data  = 16'h1111 * 16'(i + 1);
      res_flags = 2'(i);
      tick();
      if (i == 1) begin
        checks++;
        if (res_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready: got %b expected 0", res_ready);
        end
      end
    end
    res_valid = 1'b0;
    checks++;
    if ({overflow, level} !== {1'b1, LW'(2)}) begin
      errors++;
      $display("FAIL ovf_level: got %h expected %h", {overflow, level}, {1'b1, LW'(2)});
    end
    for (int i = 0; i < 2*NB + 2; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_read%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      pulse(3, 3);
    end
    checks++;
    if ({overflow, byte_valid, level} !== {1'b1, 1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL ovf_sticky: got %h expected %h", {overflow, byte_valid, level}, {1'b1, 1'b0, LW'(0)});
    end
  endtask

  task automatic test_strobe_edges();
    push(16'hBEEF, 2'b10);
    tick();
    pulse(20, 3);
    checks++;
    if ({byte_valid, byte_sel} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL held_strobe: got %h expected %h", {byte_valid, byte_sel}, {1'b1, 2'd1});
    end
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    repeat (4) tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL short_pulse: got %h expected %h", dut_vec, exp_vec());
    end
    drain();
    pulse(3, 3);
    pulse(3, 3);
    push(16'h5A3C, 2'b00);
    tick();
    checks++;
    if ({byte_valid, byte_sel, byte_out} !== {1'b1, 2'd0, 8'h3C}) begin
      errors++;
      $display("FAIL idle_strobe_lo: got %h expected %h", {byte_valid, byte_sel, byte_out}, {1'b1, 2'd0, 8'h3C});
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    push(16'hA1B2, 2'b01);
    push(16'hC3D4, 2'b00);
    tick();
    pulse(3, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dut_vec !== {1'b0, 2'd0, 8'h00, 1'b1, 1'b0, LW'(0)}) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", dut_vec, {1'b0, 2'd0, 8'h00, 1'b1, 1'b0, LW'(0)});
    end
    push(16'h7788, 2'b00);
    tick();
    checks++;
    if ({byte_valid, byte_sel, byte_out} !== {1'b1, 2'd0, 8'h88}) begin
      errors++;
      $display("FAIL post_reset_lo: got %h expected %h", {byte_valid, byte_sel, byte_out}, {1'b1, 2'd0, 8'h88});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    push(16'h2211, 2'b00);
    tick();
    repeat (NB - 1) pulse(3, 3);
    rd_strobe = 1'b1;
    tick();
    tick();
    res_valid = 1'b1;
    res_data  = 16'h6655;
    res_flags = 2'b01;
    tick();
    res_valid = 1'b0;
    checks++;
    if ({level, byte_valid} !== {LW'(1), 1'b0}) begin
      errors++;
      $display("FAIL concur_level: got %h expected %h", {level, byte_valid}, {LW'(1), 1'b0});
    end
    tick();
    checks++;
    if ({byte_valid, byte_sel, byte_out, level} !== {1'b1, 2'd0, 8'h55, LW'(1)}) begin
      errors++;
      $display("FAIL concur_lo: got %h expected %h", {byte_valid, byte_sel, byte_out, level}, {1'b1, 2'd0, 8'h55, LW'(1)});
    end
    rd_strobe = 1'b0;
    repeat (3) tick();
    drain();
  endtask

  task automatic test_random();
    int run = 0;
    for (int c = 0; c < 3000; c++) begin
      res_valid = ($urandom_range(0, 3) == 0);
      res_data  = 16'($urandom);
      res_flags = 2'($urandom);
      if (run == 0) begin
        rd_strobe = ~rd_strobe;
        run = $urandom_range(1, 6);
      end
      run--;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    res_valid = 1'b0;
    rd_strobe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_overflow();
    test_reset();
    test_strobe_edges();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
